// File: rtl/wb_openram_mport.sv
// wb_openram_mport: round-robin multi-port Wishbone front-end driving one OpenRAM RW port
module wb_openram_mport #(
  parameter int NUM_PORTS      = 2,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_WIDTH     = 4
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic [WAIT_WIDTH-1:0]                 cfg_wait_i,
  input  logic [NUM_PORTS-1:0]                  wbs_cyc_i,
  input  logic [NUM_PORTS-1:0]                  wbs_stb_i,
  input  logic [NUM_PORTS-1:0]                  wbs_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]     wbs_sel_i,
  input  logic [NUM_PORTS*(RAM_ADDR_WIDTH+2)-1:0] wbs_adr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_i,
  output logic [NUM_PORTS-1:0]                  wbs_ack_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]       wbs_dat_o,
  output logic                                  ram_clk0,
  output logic                                  ram_csb0,
  output logic                                  ram_web0,
  output logic [DATA_WIDTH/8-1:0]               ram_wmask0,
  output logic [RAM_ADDR_WIDTH-1:0]             ram_addr0,
  output logic [DATA_WIDTH-1:0]                 ram_din0,
  input  logic [DATA_WIDTH-1:0]                 ram_dout0
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = RAM_ADDR_WIDTH + 2;
  localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, WAIT, ACK} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr, grant, arb;
  logic any_req, done, unused_adr;
  logic [NUM_PORTS-1:0] req, rot;
  logic [WAIT_WIDTH-1:0] cnt;
  logic [SW-1:0] sel_a [NUM_PORTS];
  logic [RAM_ADDR_WIDTH-1:0] adr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0] din_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dat_q [NUM_PORTS];
  assign req = wbs_cyc_i & wbs_stb_i;
  assign rot = NUM_PORTS'({req, req} >> rr_ptr);
  assign done = state == CLK_HI ? cnt == '0 : cnt == WAIT_WIDTH'(1);
  assign unused_adr = ^wbs_adr_i;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign sel_a[p] = wbs_sel_i[p*SW +: SW];
    assign adr_a[p] = wbs_adr_i[p*AW+2 +: RAM_ADDR_WIDTH];
    assign din_a[p] = wbs_dat_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign wbs_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = dat_q[p];
  end
  // descending scan so the requester closest to rr_ptr wins
  always_comb begin
    arb = rr_ptr;
    any_req = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (rot[i]) begin
        arb = GW'((int'(rr_ptr) + i) % NUM_PORTS);
        any_req = 1'b1;
      end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      cnt <= '0;
      ram_clk0 <= 1'b0;
      ram_csb0 <= 1'b1;
      ram_web0 <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0 <= '0;
      ram_din0 <= '0;
      wbs_ack_o <= '0;
      for (int i = 0; i < NUM_PORTS; i++) dat_q[i] <= '0;
    end else begin
      wbs_ack_o <= '0;
      case (state)
        IDLE: if (any_req) begin
          grant <= arb;
          ram_addr0 <= adr_a[arb];
          ram_din0 <= din_a[arb];
          ram_wmask0 <= wbs_we_i[arb] ? sel_a[arb] : '0;
          ram_web0 <= !wbs_we_i[arb];
          ram_csb0 <= 1'b0;
          cnt <= cfg_wait_i;
          state <= SETUP;
        end
        SETUP: if (req[grant]) begin
          ram_clk0 <= 1'b1;
          state <= CLK_HI;
        end else begin
          ram_csb0 <= 1'b1;
          ram_web0 <= 1'b1;
          state <= IDLE;
        end
        CLK_HI, WAIT: if (done) begin
          if (ram_web0) dat_q[grant] <= ram_dout0;
          wbs_ack_o <= req[grant] ? NUM_PORTS'(1) << grant : '0;
          ram_clk0 <= 1'b0;
          ram_csb0 <= 1'b1;
          ram_web0 <= 1'b1;
          state <= ACK;
        end else begin
          cnt <= cnt - WAIT_WIDTH'(state == WAIT);
          state <= WAIT;
        end
        ACK: begin
          rr_ptr <= grant == GW'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_openram_mport.sv
// tb_wb_openram_mport: directed and randomized checks against a behavioural RAM/arbiter model
module tb_wb_openram_mport;
  localparam int N = 2, AW = 8, DW = 32, WW = 4, SW = DW / 8, BW = AW + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WW-1:0] cfg = '0;
  logic [N-1:0] cyc_i = '0, stb_i = '0, we_i = '0;
  logic [N*SW-1:0] sel_i = '0;
  logic [N*BW-1:0] adr_i = '0;
  logic [N*DW-1:0] dat_i = '0;
  logic [N-1:0] ack;
  logic [N*DW-1:0] dat_o;
  logic ram_clk0, ram_csb0, ram_web0;
  logic [SW-1:0] ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [DW-1:0] ram_din0;
  logic [DW-1:0] ram_dout0 = '0;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] mem_init [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic mem_load = 1'b0;
  int checks = 0, errors = 0, cyc = 0, rises = 0, multi = 0;

  wb_openram_mport #(.NUM_PORTS(N), .RAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_WIDTH(WW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_wait_i(cfg),
    .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
    .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
    .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge ram_clk0) rises <= rises + 1;
  always @(negedge clk) if ($countones(ack) > 1) multi <= multi + 1;

  // macro model: acts on the rising edge of ram_clk0 while selected
  always @(posedge ram_clk0 or posedge mem_load)
    if (mem_load) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= mem_init[i];
    end else if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int b = 0; b < SW; b++)
          if (ram_wmask0[b]) mem[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
      end else ram_dout0 <= mem[ram_addr0];
    end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    mem_load = 1'b1;
    #1;
    mem_load = 1'b0;
  endtask

  task automatic drive(input int p, input bit we, input logic [BW-1:0] adr, input logic [SW-1:0] sel, input logic [DW-1:0] d);
    cyc_i[p] = 1'b1;
    stb_i[p] = 1'b1;
    we_i[p] = we;
    adr_i[p*BW +: BW] = adr;
    sel_i[p*SW +: SW] = sel;
    dat_i[p*DW +: DW] = d;
  endtask

  task automatic release_p(input int p);
    cyc_i[p] = 1'b0;
    stb_i[p] = 1'b0;
  endtask

  task automatic wait_ack(input int p, input int limit, output int at, output int other);
    at = -1;
    other = 0;
    for (int k = 0; k < limit && at < 0; k++) begin
      @(negedge clk);
      if (ack[p]) at = cyc;
      for (int q = 0; q < N; q++) if (q != p && ack[q]) other++;
    end
  endtask

  function automatic int first_from(input logic [N-1:0] m, input int ptr);
    for (int i = 0; i < N; i++) if (m[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ram_clk0 !== 1'b0) begin errors++; $display("FAIL reset_clk0 got %b exp 0", ram_clk0); end
    checks++; if (ram_csb0 !== 1'b1) begin errors++; $display("FAIL reset_csb0 got %b exp 1", ram_csb0); end
    checks++; if (ram_web0 !== 1'b1) begin errors++; $display("FAIL reset_web0 got %b exp 1", ram_web0); end
    checks++; if (ram_wmask0 !== '0) begin errors++; $display("FAIL reset_wmask got %h exp 0", ram_wmask0); end
    checks++; if (ram_addr0 !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", ram_addr0); end
    checks++; if (ram_din0 !== '0) begin errors++; $display("FAIL reset_din got %h exp 0", ram_din0); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (dat_o !== '0) begin errors++; $display("FAIL reset_dat got %h exp 0", dat_o); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_read();
    int t0, r0, at, oth, late;
    cfg = 4'd2;
    step();
    t0 = cyc;
    r0 = rises;
    drive(0, 1'b0, 10'h010, 4'hF, $urandom);
    repeat (2) @(negedge clk);
    checks++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 8'h04) begin errors++; $display("FAIL read_setup csb=%b addr=%h exp csb=0 addr=04", ram_csb0, ram_addr0); end
    checks++; if (ram_web0 !== 1'b1 || ram_wmask0 !== 4'h0) begin errors++; $display("FAIL read_ctrl web=%b wmask=%h exp web=1 wmask=0", ram_web0, ram_wmask0); end
    wait_ack(0, 20, at, oth);
    checks++; if (at != t0 + 5) begin errors++; $display("FAIL read_latency got %0d exp %0d", at - t0, 5); end
    checks++; if (dat_o[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", dat_o[DW-1:0]); end
    checks++; if (rises - r0 != 1) begin errors++; $display("FAIL read_clk_edges got %0d exp 1", rises - r0); end
    release_p(0);
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack !== '0) late++;
    end
    checks++; if (late != 0 || oth != 0) begin errors++; $display("FAIL read_extra_ack got %0d exp 0", late + oth); end
  endtask

  task automatic test_write();
    int t0, at, oth;
    logic [DW-1:0] old1, oldm;
    cfg = 4'd0;
    old1 = dat_o[DW +: DW];
    oldm = mem[255];
    step();
    t0 = cyc;
    drive(1, 1'b1, 10'h3FC, 4'b0101, 32'h11223344);
    repeat (2) @(negedge clk);
    checks++; if (ram_addr0 !== 8'hFF || ram_web0 !== 1'b0) begin errors++; $display("FAIL write_setup addr=%h web=%b exp addr=ff web=0", ram_addr0, ram_web0); end
    checks++; if (ram_wmask0 !== 4'b0101 || ram_din0 !== 32'h11223344) begin errors++; $display("FAIL write_data wmask=%b din=%h exp 0101 11223344", ram_wmask0, ram_din0); end
    wait_ack(1, 20, at, oth);
    checks++; if (at != t0 + 3 || oth != 0) begin errors++; $display("FAIL write_latency got %0d exp %0d", at - t0, 3); end
    checks++; if (dat_o[DW +: DW] !== old1) begin errors++; $display("FAIL write_dat_hold got %h exp %h", dat_o[DW +: DW], old1); end
    checks++; if (mem[255] !== ((oldm & 32'hFF00FF00) | 32'h00220044)) begin errors++; $display("FAIL write_mem got %h exp %h", mem[255], (oldm & 32'hFF00FF00) | 32'h00220044); end
    release_p(1);
    step();
  endtask

  task automatic test_round_robin();
    int seen, exp, last, p;
    cfg = 4'd1;
    step();
    drive(0, 1'b0, 10'h100, 4'hF, '0);
    drive(1, 1'b0, 10'h204, 4'hF, '0);
    exp = (1 + 1) % N;
    seen = 0;
    last = -1;
    for (int k = 0; k < 80 && seen < 4; k++) begin
      @(negedge clk);
      if (ack !== '0) begin
        p = -1;
        for (int q = 0; q < N; q++) if (ack[q]) p = q;
        checks++; if (p != exp) begin errors++; $display("FAIL rr_order got %0d exp %0d", p, exp); end
        if (last >= 0) begin
          checks++; if (cyc - last != 5) begin errors++; $display("FAIL rr_spacing got %0d exp 5", cyc - last); end
        end
        last = cyc;
        exp = (exp + 1) % N;
        seen++;
        if (seen == 4) begin
          release_p(0);
          release_p(1);
        end
      end
    end
    checks++; if (seen != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", seen); end
    checks++; if (multi != 0) begin errors++; $display("FAIL rr_overlap got %0d exp 0", multi); end
    release_p(0);
    release_p(1);
    step();
  endtask

  task automatic test_abort();
    int t0, r0, at, oth;
    cfg = 4'd1;
    step();
    t0 = cyc;
    r0 = rises;
    drive(0, 1'b0, 10'h030, 4'hF, '0);
    step();
    release_p(0);
    drive(1, 1'b0, 10'h020, 4'hF, '0);
    repeat (2) @(negedge clk);
    checks++; if (ram_csb0 !== 1'b1 || rises != r0) begin errors++; $display("FAIL abort_idle csb=%b edges=%0d exp csb=1 edges=0", ram_csb0, rises - r0); end
    wait_ack(1, 20, at, oth);
    checks++; if (at != t0 + 6) begin errors++; $display("FAIL abort_next_latency got %0d exp %0d", at - t0, 6); end
    checks++; if (oth != 0) begin errors++; $display("FAIL abort_port0_ack got %0d exp 0", oth); end
    checks++; if (rises - r0 != 1) begin errors++; $display("FAIL abort_edges got %0d exp 1", rises - r0); end
    release_p(1);
    step();
  endtask

  task automatic test_reset_wait();
    int t0, at, oth, late;
    cfg = 4'd3;
    step();
    t0 = cyc;
    drive(0, 1'b0, 10'h040, 4'hF, '0);
    repeat (4) @(negedge clk);
    checks++; if (ram_clk0 !== 1'b1) begin errors++; $display("FAIL rstw_in_wait got %b exp 1", ram_clk0); end
    rst = 1'b1;
    release_p(0);
    @(negedge clk);
    checks++; if (ram_clk0 !== 1'b0 || ram_csb0 !== 1'b1 || ram_web0 !== 1'b1) begin errors++; $display("FAIL rstw_ctrl clk=%b csb=%b web=%b exp 0 1 1", ram_clk0, ram_csb0, ram_web0); end
    checks++; if (ram_wmask0 !== '0 || ram_addr0 !== '0 || ram_din0 !== '0) begin errors++; $display("FAIL rstw_bus wmask=%h addr=%h din=%h exp 0", ram_wmask0, ram_addr0, ram_din0); end
    checks++; if (ack !== '0 || dat_o !== '0) begin errors++; $display("FAIL rstw_wb ack=%b dat=%h exp 0", ack, dat_o); end
    rst = 1'b0;
    late = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack !== '0) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rstw_no_ack got %0d exp 0", late); end
    cfg = 4'd2;
    step();
    t0 = cyc;
    drive(0, 1'b0, 10'h010, 4'hF, '0);
    wait_ack(0, 20, at, oth);
    checks++; if (at != t0 + 5) begin errors++; $display("FAIL rstw_relatency got %0d exp %0d", at - t0, 5); end
    checks++; if (dat_o[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstw_data got %h exp deadbeef", dat_o[DW-1:0]); end
    release_p(0);
    step();
  endtask

  task automatic test_drop_wait();
    int t0, r0, at, oth, late;
    cfg = 4'd2;
    step();
    t0 = cyc;
    r0 = rises;
    drive(0, 1'b0, 10'h008, 4'hF, '0);
    repeat (4) @(negedge clk);
    release_p(0);
    repeat (2) @(negedge clk);
    checks++; if (ram_clk0 !== 1'b0 || ram_csb0 !== 1'b1) begin errors++; $display("FAIL drop_complete clk=%b csb=%b exp 0 1", ram_clk0, ram_csb0); end
    checks++; if (rises - r0 != 1) begin errors++; $display("FAIL drop_edges got %0d exp 1", rises - r0); end
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack !== '0) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL drop_no_ack got %0d exp 0", late); end
    step();
    t0 = cyc;
    drive(0, 1'b0, 10'h00C, 4'hF, '0);
    drive(1, 1'b0, 10'h014, 4'hF, '0);
    wait_ack(1, 20, at, oth);
    checks++; if (at != t0 + 5 || oth != 0) begin errors++; $display("FAIL drop_rr_next got %0d other=%0d exp %0d other=0", at - t0, oth, 5); end
    release_p(0);
    release_p(1);
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    int ptr, nxt, exp_at, p, to;
    logic [BW-1:0] a;
    logic [DW-1:0] exp_d;
    bit r_we [N];
    logic [AW-1:0] r_w [N];
    logic [SW-1:0] r_sel [N];
    logic [DW-1:0] r_dat [N];
    logic [DW-1:0] last_rd [N];
    for (int q = 0; q < N; q++) release_p(q);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      mem_init[i] = $urandom;
      ref_mem[i] = mem_init[i];
    end
    load_mem();
    for (int q = 0; q < N; q++) last_rd[q] = '0;
    ptr = 0;
    for (int it = 0; it < 40; it++) begin
      pend = N'($urandom_range(1, 2**N - 1));
      cfg = WW'($urandom_range(0, 5));
      step();
      exp_at = cyc + 3 + int'(cfg);
      for (int q = 0; q < N; q++)
        if (pend[q]) begin
          a = BW'($urandom);
          r_we[q] = 1'($urandom);
          r_w[q] = a[BW-1:2];
          r_sel[q] = SW'($urandom);
          r_dat[q] = $urandom;
          drive(q, r_we[q], a, r_sel[q], r_dat[q]);
        end
      nxt = first_from(pend, ptr);
      to = 0;
      while (pend != '0 && to < 200) begin
        @(negedge clk);
        to++;
        if (ack !== '0) begin
          p = 0;
          for (int q = 0; q < N; q++) if (ack[q]) p = q;
          checks++; if (p != nxt) begin errors++; $display("FAIL rand_grant it=%0d got %0d exp %0d", it, p, nxt); end
          checks++; if (cyc != exp_at) begin errors++; $display("FAIL rand_latency it=%0d got %0d exp %0d", it, cyc, exp_at); end
          if (r_we[p]) begin
            for (int b = 0; b < SW; b++) if (r_sel[p][b]) ref_mem[r_w[p]][8*b +: 8] = r_dat[p][8*b +: 8];
            checks++; if (dat_o[p*DW +: DW] !== last_rd[p]) begin errors++; $display("FAIL rand_wr_hold it=%0d got %h exp %h", it, dat_o[p*DW +: DW], last_rd[p]); end
          end else begin
            exp_d = ref_mem[r_w[p]];
            last_rd[p] = exp_d;
            checks++; if (dat_o[p*DW +: DW] !== exp_d) begin errors++; $display("FAIL rand_rd_data it=%0d got %h exp %h", it, dat_o[p*DW +: DW], exp_d); end
          end
          release_p(p);
          pend[p] = 1'b0;
          ptr = (p + 1) % N;
          if (pend != '0) begin
            nxt = first_from(pend, ptr);
            exp_at = cyc + 4 + int'(cfg);
          end
        end else if (ram_csb0 === 1'b0 && $urandom_range(0, 2) == 0) cfg = WW'($urandom_range(0, 5));
      end
      checks++; if (pend != '0) begin errors++; $display("FAIL rand_timeout it=%0d pending %b exp 0", it, pend); end
      for (int q = 0; q < N; q++) release_p(q);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem_init[i] = $urandom;
    mem_init[4] = 32'hDEADBEEF;
    load_mem();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_abort();
    test_reset_wait();
    test_drop_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_openram_mport.md
Name: wb_openram_mport

Overview:
- Multi-port Wishbone slave front-end for a single OpenRAM RW port (port 0).
- NUM_PORTS independent Wishbone masters share the macro through a round-robin arbiter.
- One transaction is in flight at a time. An FSM generates ram_clk0 with a programmable high-phase length, which replaces free-running clock stretching.
- Sits between the Caravel-side Wishbone interconnect and one sky130 OpenRAM macro; the whole block runs in one clock domain.

Parameters:
- NUM_PORTS, 2, number of Wishbone slave ports (1..8).
- RAM_ADDR_WIDTH, 8, word-address width of the macro.
- DATA_WIDTH, 32, data width; multiple of 8.
- WAIT_WIDTH, 4, width of cfg_wait_i.

Ports:
- wb_clk_i  in  1  block clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cfg_wait_i  in  WAIT_WIDTH  extra ram_clk0 high cycles; sampled at grant.
- wbs_cyc_i  in  NUM_PORTS  per-port cycle.
- wbs_stb_i  in  NUM_PORTS  per-port strobe.
- wbs_we_i  in  NUM_PORTS  per-port write enable.
- wbs_sel_i  in  NUM_PORTS*DATA_WIDTH/8  byte selects; port p occupies slice p.
- wbs_adr_i  in  NUM_PORTS*(RAM_ADDR_WIDTH+2)  byte addresses; slice p.
- wbs_dat_i  in  NUM_PORTS*DATA_WIDTH  write data; slice p.
- wbs_ack_o  out  NUM_PORTS  per-port ack.
- wbs_dat_o  out  NUM_PORTS*DATA_WIDTH  read data; slice p.
- ram_clk0  out  1  macro clock, FSM-generated and registered.
- ram_csb0  out  1  active-low chip select.
- ram_web0  out  1  active-low write enable.
- ram_wmask0  out  DATA_WIDTH/8  byte write mask.
- ram_addr0  out  RAM_ADDR_WIDTH  word address.
- ram_din0  out  DATA_WIDTH  macro write data.
- ram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- All outputs are registered; the single clock is wb_clk_i and the only reset is wb_rst_i.
- Reset values:
  - state IDLE, rr_ptr 0
  - ram_clk0 0, ram_csb0 1, ram_web0 1
  - ram_wmask0 0, ram_addr0 0, ram_din0 0
  - wbs_ack_o 0, wbs_dat_o 0
- Request: req[p] = wbs_cyc_i[p] & wbs_stb_i[p].
- Word address: wbs_adr_i slice bits [RAM_ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- IDLE:
  - If any req is set, grant the first requesting port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register grant, addr and din. Register wmask = sel on write, 0 on read. Register web = !we.
  - Set csb0=0, latch W = cfg_wait_i, go to SETUP.
- SETUP (1 cycle, ram_clk0=0):
  - If req[grant]=0: go to IDLE, set csb0=1, no clock edge, no ack.
  - Otherwise go to CLK_HI.
- CLK_HI (1 cycle): ram_clk0=1 (rising edge launches the RAM op). Go to WAIT if W>0, else go to ACK.
- WAIT (W cycles): ram_clk0 stays 1; a down-counter runs. On the last cycle go to ACK.
- Entering ACK:
  - Capture ram_dout0 into wbs_dat_o[grant] if it was a read.
  - Drive ram_clk0=0, csb0=1, web0=1.
- ACK (1 cycle):
  - wbs_ack_o[grant]=1 only if req[grant] is still 1. If the master has dropped, the op completes silently.
  - rr_ptr = (grant+1) mod NUM_PORTS. Go to IDLE.
- Latency: request present in IDLE cycle t → ack in cycle t+3+W. Minimum gap between back-to-back grants is 4+W cycles.
- Ack is a single-cycle pulse, never asserted on more than one port. A port whose request is held after ack is re-arbitrated as a new request.
- On a write, wbs_dat_o[grant] is unchanged. Every wbs_dat_o slice holds its last read value until overwritten or reset.
- Requests arriving outside IDLE wait and are not lost (the master holds stb per Wishbone).
- Changes to cfg_wait_i mid-transaction have no effect until the next grant.
- Reset asserted in any state forces the reset values on the next edge:
  - any pending ack is dropped;
  - ram_clk0 returns to 0 (a write already launched by CLK_HI may have completed).
- NUM_PORTS=1: arbitration is trivial and rr_ptr stays 0.

Test Plan:
- Port 0 read, adr=0x010, cfg_wait_i=2, ram_dout0=0xDEADBEEF → ram_addr0=0x04, ram_web0=1, ram_wmask0=0; one ram_clk0 rising edge; wbs_ack_o[0] pulses exactly 5 cycles after the request; wbs_dat_o[0]=0xDEADBEEF.
- Port 1 write, adr=0x3FC, sel=4'b0101, dat=0x11223344, W=0 → ram_addr0=0xFF, ram_web0=0, ram_wmask0=4'b0101, ram_din0=0x11223344; ack[1] 3 cycles after the request; wbs_dat_o[1] unchanged.
- Ports 0 and 1 request simultaneously and keep requesting → grants alternate 0,1,0,1; acks never overlap; spacing is 4+W cycles.
- Port 0 drops cyc during SETUP → ram_csb0 returns to 1, no ram_clk0 rising edge, no ack; a port 1 request pending at that time is granted next.
- wb_rst_i pulsed during WAIT of a read → next cycle all outputs at reset values, no ack; a new request afterwards completes with normal latency.
- Port 0 drops stb during WAIT → RAM cycle completes (ram_clk0 falls, csb0 returns to 1); wbs_ack_o stays 0; rr_ptr advances to 1.
